// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Bundles the operand, control and result signals of the sequential
//   multiply/divide unit. Clock and reset are not part of the bundle.
//   master: the requester (drives operands and start strobes, reads results)
//   slave : the multiply/divide unit itself
//
//   Operand1      multiplicand / dividend
//   Operand2      multiplier / divisor
//   Signed_Op     1 = two's-complement operands, sampled with a start
//   mult_start    request a multiply (wins over div_start)
//   div_start     request a divide
//   Result_Lo     product low half / quotient
//   Result_Hi     product high half / remainder
//   mult_div_done one-cycle completion pulse
//   Busy          operation in progress, starts ignored
//   DZ_OUT        divide-by-zero flag of the last completed divide
interface mult_div_unit_if #(
  parameter int OPERAND_WIDTH = 32
);
  logic [OPERAND_WIDTH-1:0] Operand1;
  logic [OPERAND_WIDTH-1:0] Operand2;
  logic                     Signed_Op;
  logic                     mult_start;
  logic                     div_start;
  logic [OPERAND_WIDTH-1:0] Result_Lo;
  logic [OPERAND_WIDTH-1:0] Result_Hi;
  logic                     mult_div_done;
  logic                     Busy;
  logic                     DZ_OUT;

  modport master (
    output Operand1, Operand2, Signed_Op, mult_start, div_start,
    input  Result_Lo, Result_Hi, mult_div_done, Busy, DZ_OUT
  );

  modport slave (
    input  Operand1, Operand2, Signed_Op, mult_start, div_start,
    output Result_Lo, Result_Hi, mult_div_done, Busy, DZ_OUT
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Radix-2 iterative multiply/divide unit with signed and unsigned modes.
//   Multiply: one shift-add step per cycle into a double-width accumulator.
//   Divide  : one restoring subtract step per cycle, quotient shifted into
//             the low accumulator half, partial remainder kept separately.
//   Operands are reduced to magnitudes on accept and signs are restored in
//   a single FIX cycle before the results are published.
//
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : slave side of mult_div_unit_if (operands, starts, results, status)
module mult_div_unit #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic            CLK,
  input  logic            RST,
  mult_div_unit_if.slave  bus
);

  localparam int W         = OPERAND_WIDTH;
  localparam int CNT_WIDTH = $clog2(OPERAND_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(OPERAND_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_op_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic [2*W-1:0]       r_acc;
  logic [W:0]           r_rem;

  logic [W-1:0]         r_res_lo;
  logic [W-1:0]         r_res_hi;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_dz;

  logic                 w_accept;
  logic                 w_req_div;
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [W-1:0]         w_mag1;
  logic [W-1:0]         w_mag2;
  logic                 w_dz;
  logic [W-1:0]         w_addend;
  logic [W:0]           w_sum;
  logic [W:0]           w_shift;
  logic                 w_ge;
  logic [W:0]           w_diff;
  logic [2*W-1:0]       w_prod;
  logic [W-1:0]         w_quo;
  logic [W-1:0]         w_rem;

  assign bus.Result_Lo     = r_res_lo;
  assign bus.Result_Hi     = r_res_hi;
  assign bus.mult_div_done = r_done;
  assign bus.Busy          = r_busy;
  assign bus.DZ_OUT        = r_dz;

  // Starts are only honoured in IDLE and DONE; multiply has priority.
  assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                     (bus.mult_start || bus.div_start);
  assign w_req_div = ~bus.mult_start;

  assign w_op1_neg = bus.Signed_Op & bus.Operand1[W-1];
  assign w_op2_neg = bus.Signed_Op & bus.Operand2[W-1];
  assign w_mag1    = w_op1_neg ? -bus.Operand1 : bus.Operand1;
  assign w_mag2    = w_op2_neg ? -bus.Operand2 : bus.Operand2;
  assign w_dz      = w_req_div && (bus.Operand2 == '0);

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (LSB of accumulator) is set, then shift right by one with
  // the carry entering at the top.
  assign w_addend = r_acc[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};

  // Restoring step: the next dividend bit comes from the MSB of the low
  // accumulator half, which doubles as the quotient shift register.
  assign w_shift = {r_rem[W-1:0], r_acc[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift - {1'b0, r_b};

  // Sign restoration applied in FIX.
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_neg_rem ? -r_rem[W-1:0] : r_rem[W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_res_lo  <= '0;
      r_res_hi  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op_div  <= w_req_div;
            r_a       <= w_mag1;
            r_b       <= w_mag2;
            r_neg_res <= w_op1_neg ^ w_op2_neg;
            r_neg_rem <= w_op1_neg;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_acc     <= w_req_div ? {{W{1'b0}}, w_mag1} : {{W{1'b0}}, w_mag2};
            if (w_dz) begin
              // Divide by zero completes immediately without iterating.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_res_lo <= '1;
              r_res_hi <= bus.Operand1;
              r_dz     <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_CALC: begin
          if (r_op_div) begin
            r_rem          <= w_ge ? w_diff : w_shift;
            r_acc[W-1:0]   <= {r_acc[W-2:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[W-1:1]};
          end
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dz    <= 1'b0;
          if (r_op_div) begin
            r_res_lo <= w_quo;
            r_res_hi <= w_rem;
          end else begin
            r_res_lo <= w_prod[W-1:0];
            r_res_hi <= w_prod[2*W-1:W];
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mult_div_unit_if #(.OPERAND_WIDTH(W)) bus ();

  mult_div_unit #(.OPERAND_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  exp_t q_exp[$];
  exp_t last_res;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the mathematical values.
  function automatic exp_t model(input bit is_mult, input bit sg,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        r;
    longint      sa, sb, sq, sr, sp;
    logic [63:0] v, vq, vr;
    r.dz = 1'b0;
    if (is_mult) begin
      if (sg) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        v  = sp;
      end else begin
        v = {32'b0, a} * {32'b0, b};
      end
      r.lo = v[31:0];
      r.hi = v[63:32];
    end else if (b == '0) begin
      r.lo = '1;
      r.hi = a;
      r.dz = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      vq = sq;
      vr = sr;
      r.lo = vq[31:0];
      r.hi = vr[31:0];
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Monitor: every done cycle consumes one expected result.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST && bus.mult_div_done === 1'b1) begin
      if (q_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = q_exp.pop_front();
        check("result_lo", 64'(bus.Result_Lo), 64'(e.lo));
        check("result_hi", 64'(bus.Result_Hi), 64'(e.hi));
        check("dz_out",    64'(bus.DZ_OUT),    64'(e.dz));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issues one operation immediately (callers sit #1 after a rising edge,
  // possibly inside a DONE cycle) and checks latency and Busy duration.
  task automatic run_op(input bit ms, input bit ds, input bit sg,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    bit   dz, seen;
    int   cyc, busy_cnt;
    exp_t e;
    dz = ds && !ms && (b == '0);
    e  = model(ms, sg, a, b);
    bus.Operand1   = a;
    bus.Operand2   = b;
    bus.Signed_Op  = sg;
    bus.mult_start = ms;
    bus.div_start  = ds;
    q_exp.push_back(e);
    cyc = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.Operand1   = $urandom;
        bus.Operand2   = $urandom;
        bus.Signed_Op  = 1'($urandom_range(0, 1));
      end
      if (poke && !dz && cyc == 5) begin
        bus.mult_start = 1'b1;
        bus.div_start  = 1'b1;
        bus.Operand1   = $urandom;
        bus.Operand2   = $urandom;
      end
      if (poke && !dz && cyc == 6) begin
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
      end
      if (!dz && cyc == W / 2) begin
        check("hold_during_calc", {bus.Result_Lo, bus.Result_Hi},
              {last_res.lo, last_res.hi});
      end
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.mult_div_done === 1'b1) seen = 1;
    end
    check("latency",      64'(cyc),      dz ? 64'd1 : 64'(W + 2));
    check("busy_cycles",  64'(busy_cnt), dz ? 64'd0 : 64'(W + 1));
    last_res = e;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = '1;
      3:       v = 32'd1;
      4:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin : stim
    int got;
    bit ms, ds, sg;
    last_res = '0;
    RST = 1'b1;
    bus.Operand1   = '0;
    bus.Operand2   = '0;
    bus.Signed_Op  = 1'b0;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    idle(2);
    check("reset_lo",   64'(bus.Result_Lo),     64'd0);
    check("reset_hi",   64'(bus.Result_Hi),     64'd0);
    check("reset_done", 64'(bus.mult_div_done), 64'd0);
    check("reset_busy", 64'(bus.Busy),          64'd0);
    check("reset_dz",   64'(bus.DZ_OUT),        64'd0);
    RST = 1'b0;
    idle(2);

    // Directed cases
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); idle(2);
    run_op(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 0);         idle(1);
    run_op(1, 0, 0, 32'hFFFF_FFFD, 32'd5, 0);         idle(1);
    run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 0);         idle(1);
    run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0); idle(1);
    run_op(0, 1, 0, 32'd100, 32'd0, 0);               idle(1);
    run_op(0, 1, 0, 32'd10, 32'd3, 0);                idle(1);
    run_op(1, 1, 0, 32'd6, 32'd4, 0);                 idle(1);
    run_op(1, 0, 0, 32'd1234, 32'd5678, 1);           idle(1);
    // Starts issued in the DONE cycle of the previous operation
    run_op(1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(0, 1, 1, 32'h8000_0001, 32'd7, 0);
    run_op(0, 1, 1, 32'hFFFF_FFF0, 32'd0, 0);
    run_op(0, 1, 0, 32'd55, 32'd0, 0);
    run_op(0, 1, 0, 32'd55, 32'd8, 0);
    idle(2);

    // Reset in the middle of a calculation
    run_op(0, 1, 0, 32'd100, 32'd0, 0);
    idle(2);
    bus.Operand1   = 32'd77;
    bus.Operand2   = 32'd9;
    bus.mult_start = 1'b1;
    tick();
    bus.mult_start = 1'b0;
    idle(9);
    check("busy_mid_calc", 64'(bus.Busy), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("arst_lo",   64'(bus.Result_Lo),     64'd0);
    check("arst_hi",   64'(bus.Result_Hi),     64'd0);
    check("arst_done", 64'(bus.mult_div_done), 64'd0);
    check("arst_busy", 64'(bus.Busy),          64'd0);
    check("arst_dz",   64'(bus.DZ_OUT),        64'd0);
    tick();
    RST = 1'b0;
    last_res = '0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.mult_div_done === 1'b1) got++;
    end
    check("no_done_after_reset", 64'(got), 64'd0);
    run_op(1, 0, 0, 32'd77, 32'd9, 0);
    idle(1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ms = 1'($urandom_range(0, 1));
      ds = ms ? ($urandom_range(0, 3) == 0) : 1'b1;
      sg = 1'($urandom_range(0, 1));
      run_op(ms, ds, sg, pick(), pick(), ($urandom_range(0, 4) == 0));
      idle($urandom_range(0, 3));
    end

    for (int i = 0; i < 10 && q_exp.size() != 0; i++) tick();
    check("queue_drained", 64'(q_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential multiply/divide unit, parametrised in operand width, with signed and unsigned modes.
- Sits beside the combinational ALU and serves the MULT/DIV operations through a start/done handshake.
- Produces a double-width result as separate Hi/Lo words.
- Radix-2 iterative: one shift-add (multiply) or one restoring subtract (divide) step per cycle.

Parameters:
- OPERAND_WIDTH, 32: width of each operand and of each result half; legal values are ≥4.
- CNT_WIDTH, $clog2(OPERAND_WIDTH)+1: iteration counter width. Localparam, not overridable.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous reset, active-high.
- Operand1  input  OPERAND_WIDTH  multiplicand / dividend.
- Operand2  input  OPERAND_WIDTH  multiplier / divisor.
- Signed_Op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- mult_start  input  1  request a multiply.
- div_start  input  1  request a divide.
- Result_Lo  output  OPERAND_WIDTH  product low half / quotient.
- Result_Hi  output  OPERAND_WIDTH  product high half / remainder.
- mult_div_done  output  1  one-cycle pulse: results are valid.
- Busy  output  1  operation in progress; new starts are ignored while high.
- DZ_OUT  output  1  divide-by-zero flag for the last completed divide.

Behaviour:
- Reset: asynchronous, active-high. FSM goes to IDLE. Result_Lo, Result_Hi, mult_div_done, Busy, DZ_OUT and all internal registers are cleared to 0. Reset mid-operation aborts it; no done pulse follows.
- States:
  - IDLE -> CALC on an accepted start.
  - CALC -> FIX after OPERAND_WIDTH steps.
  - FIX -> DONE.
  - DONE -> IDLE, or DONE -> CALC if a new start is accepted in DONE.
  - Divide-by-zero path: IDLE -> DONE directly.
- Start acceptance:
  - A start is accepted when the FSM is in IDLE or DONE.
  - mult_start and div_start both high: multiply wins, divide request dropped.
  - Starts are ignored in CALC and FIX.
  - On accept, Operand1, Operand2, Signed_Op and the operation are latched. Later changes to the inputs have no effect.
- Latency: start accepted at edge k:
  - Busy=1 from edge k+1 through the FIX cycle.
  - mult_div_done=1 for exactly the one cycle following edge k+OPERAND_WIDTH+2; Busy=0 in that cycle.
  - Back-to-back starts therefore give a throughput of one operation per OPERAND_WIDTH+2 cycles.
- Signed handling:
  - On accept, magnitudes are taken when Signed_Op=1 and the operand MSB is set.
  - Result sign is corrected in FIX:
    - product negated if the operand signs differ;
    - quotient negated if the signs differ;
    - remainder takes the dividend's sign (truncating division).
- Multiply: 2·OPERAND_WIDTH-bit accumulator; the full product is exact with no overflow. Hi = upper half, Lo = lower half.
- Divide: restoring algorithm with OPERAND_WIDTH+1-bit partial remainder. Lo = quotient, Hi = remainder.
- Signed MIN / -1: Lo=MIN, Hi=0, DZ_OUT=0. No exception.
- Divide by zero (Operand2==0 at accept):
  - FSM goes straight to DONE, so mult_div_done is asserted the cycle after edge k+1.
  - Lo = all ones, Hi = latched Operand1, DZ_OUT=1.
- DZ_OUT is updated only at completion and cleared on completion of any non-div-by-zero operation.
- Result_Lo and Result_Hi hold the last completed result until the next completion. They are not disturbed during CALC or FIX; intermediate values live in separate registers.
- mult_div_done is never asserted for more than one consecutive cycle unless back-to-back divide-by-zero operations are issued.

Test Plan:
- Unsigned mult, W=32, 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; done exactly 34 cycles after the start edge; Busy high for 33 cycles.
- Signed mult -3 × 5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. The same operands unsigned -> Hi=0x00000004, Lo=0xFFFFFFF1.
- Signed div -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0, DZ_OUT=0.
- Div 100 / 0 -> done one cycle after Busy-free accept (cycle after edge k+1); Lo=0xFFFFFFFF, Hi=0x00000064, DZ_OUT=1. A following 10 / 3 -> Lo=3, Hi=1, DZ_OUT=0.
- Start/priority rules:
  - mult_start pulsed mid-CALC -> ignored; the first result is unaffected.
  - mult_start and div_start together with 6, 4 -> product Lo=24.
  - Start in the DONE cycle -> accepted; the next done arrives 34 cycles later.
- RST asserted mid-CALC -> all outputs 0 immediately (asynchronous); no done pulse. A new op after release completes normally.
